speed_tracker: RTL and testbench

Multi-channel successor to the single-pair speed/location path. Parses framed car packets (SYNC, ID, X, Y) from the UART byte stream. Keeps the last location per car ID and computes a per-packet speed as |dx|+|dy|. Maintains NUM_SLOTS most-recently-updated cars for the LCD driver, replacing the fixed two-ID readout.

---
 rtl/speed_tracker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_speed_tracker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_tracker.sv
// speed_tracker: parses framed car packets {SYNC, ID, X, Y} from a UART
// byte stream, remembers the last location of every car ID, reports a
// per-packet speed |dx|+|dy| (saturated) and keeps the NUM_SLOTS most
// recently updated cars for the LCD driver.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_rx_data      received byte
//   i_rx_valid     one-cycle strobe qualifying i_rx_data
//   o_id           ID of the latest speed result
//   o_speed        latest speed result
//   o_speed_valid  one-cycle pulse, o_id/o_speed valid
//   o_slot_id      slot k at [k*ID_W +: ID_W], slot 0 newest
//   o_slot_speed   slot k at [k*SPEED_W +: SPEED_W]
//   o_slot_valid   slot occupied flags
//   o_err_cnt      framing error count, saturating at 255
//
// ID_W must be smaller than DATA_W; SPEED_W must be below 32.
module speed_tracker #(
  parameter int              DATA_W    = 8,
  parameter int              ID_W      = 4,
  parameter int              SPEED_W   = 8,
  parameter int              NUM_SLOTS = 2,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter int              TIMEOUT   = 52080
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            i_rx_data,
  input  logic                         i_rx_valid,
  output logic [ID_W-1:0]              o_id,
  output logic [SPEED_W-1:0]           o_speed,
  output logic                         o_speed_valid,
  output logic [NUM_SLOTS*ID_W-1:0]    o_slot_id,
  output logic [NUM_SLOTS*SPEED_W-1:0] o_slot_speed,
  output logic [NUM_SLOTS-1:0]         o_slot_valid,
  output logic [7:0]                   o_err_cnt
);

  localparam int          DEPTH   = 2 ** ID_W;
  localparam int          CNT_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned SPD_MAX = (2 ** SPEED_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_ID = 3'd1,
    S_GET_X  = 3'd2,
    S_GET_Y  = 3'd3,
    S_LOOKUP = 3'd4,
    S_CALC   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                err_inc;

  logic                hit_q;
  logic [ID_W-1:0]     out_id_q;
  logic [SPEED_W-1:0]  speed_q;
  logic                speed_valid_q;
  logic [7:0]          err_cnt_q;

  logic [DEPTH-1:0]    tbl_vld_q;
  logic [DATA_W-1:0]   tbl_x_q [DEPTH];
  logic [DATA_W-1:0]   tbl_y_q [DEPTH];

  logic                old_vld;
  logic [DATA_W-1:0]   old_x, old_y;
  logic [DATA_W:0]     dx, dy;
  logic [DATA_W+1:0]   sum;
  logic [31:0]         sum_ext;
  logic [SPEED_W-1:0]  speed_sat;

  logic [ID_W-1:0]     slot_id_q  [NUM_SLOTS];
  logic [ID_W-1:0]     slot_id_d  [NUM_SLOTS];
  logic [SPEED_W-1:0]  slot_spd_q [NUM_SLOTS];
  logic [SPEED_W-1:0]  slot_spd_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_vld_q, slot_vld_d;
  int unsigned         match_idx;

  // Frame parser next state, byte latches, timeout counter and error strobe.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    id_d     = id_q;
    x_d      = x_q;
    y_d      = y_q;
    err_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
          state_d = S_GET_ID;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GET_ID, S_GET_X, S_GET_Y: begin
        if (i_rx_valid) begin
          case (state_q)
            S_GET_ID: begin
              if (i_rx_data[DATA_W-1:ID_W] != '0) begin
                err_inc = 1'b1;
                state_d = S_IDLE;
              end else begin
                id_d    = i_rx_data[ID_W-1:0];
                state_d = S_GET_X;
              end
            end
            S_GET_X: begin
              x_d     = i_rx_data;
              state_d = S_GET_Y;
            end
            default: begin
              y_d     = i_rx_data;
              state_d = S_LOOKUP;
            end
          endcase
        end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abandon the frame.
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      S_LOOKUP: begin
        err_inc = i_rx_valid;
        state_d = S_CALC;
      end
      S_CALC: begin
        err_inc = i_rx_valid;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Distance from the stored location to the latched one, saturated.
  always_comb begin
    old_vld = tbl_vld_q[id_q];
    old_x   = tbl_x_q[id_q];
    old_y   = tbl_y_q[id_q];
    dx      = (x_q >= old_x) ? ({1'b0, x_q} - {1'b0, old_x}) : ({1'b0, old_x} - {1'b0, x_q});
    dy      = (y_q >= old_y) ? ({1'b0, y_q} - {1'b0, old_y}) : ({1'b0, old_y} - {1'b0, y_q});
    sum     = {1'b0, dx} + {1'b0, dy};
    sum_ext = 32'(sum);
    if (sum_ext > SPD_MAX) begin
      speed_sat = SPEED_W'(SPD_MAX);
    end else begin
      speed_sat = SPEED_W'(sum_ext);
    end
  end

  // Parser state, lookup result and output registers.
  // The LOOKUP cycle registers the table read; the result registers are
  // loaded on that same edge so the pulse is visible during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      id_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hit_q         <= 1'b0;
      out_id_q      <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      id_q          <= id_d;
      x_q           <= x_d;
      y_q           <= y_d;
      speed_valid_q <= 1'b0;
      if (state_q == S_LOOKUP) begin
        hit_q <= old_vld;
        if (old_vld) begin
          out_id_q      <= id_q;
          speed_q       <= speed_sat;
          speed_valid_q <= 1'b1;
        end
      end
      if (err_inc && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Location table; only a completed frame (CALC) writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_x_q[i] <= '0;
        tbl_y_q[i] <= '0;
      end
    end else if (state_q == S_CALC) begin
      tbl_vld_q[id_q] <= 1'b1;
      tbl_x_q[id_q]   <= x_q;
      tbl_y_q[id_q]   <= y_q;
    end
  end

  // Most-recent slot list: shift down up to the matching slot (or the last
  // slot when the ID is new, evicting it) and insert at slot 0.
  always_comb begin
    slot_id_d  = slot_id_q;
    slot_spd_d = slot_spd_q;
    slot_vld_d = slot_vld_q;
    match_idx  = NUM_SLOTS - 1;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_vld_q[k] && (slot_id_q[k] == id_q)) begin
        match_idx = k;
      end
    end
    if ((state_q == S_CALC) && hit_q) begin
      for (int k = 1; k < NUM_SLOTS; k++) begin
        if (k <= match_idx) begin
          slot_id_d[k]  = slot_id_q[k-1];
          slot_spd_d[k] = slot_spd_q[k-1];
          slot_vld_d[k] = slot_vld_q[k-1];
        end
      end
      slot_id_d[0]  = id_q;
      slot_spd_d[0] = speed_q;
      slot_vld_d[0] = 1'b1;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_id_q[k]  <= '0;
        slot_spd_q[k] <= '0;
      end
    end else begin
      slot_id_q  <= slot_id_d;
      slot_spd_q <= slot_spd_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot_pack
    assign o_slot_id[k*ID_W +: ID_W]          = slot_id_q[k];
    assign o_slot_speed[k*SPEED_W +: SPEED_W] = slot_spd_q[k];
  end

  assign o_slot_valid  = slot_vld_q;
  assign o_id          = out_id_q;
  assign o_speed       = speed_q;
  assign o_speed_valid = speed_valid_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_speed_tracker.sv
// Self-checking bench for speed_tracker: directed scenarios followed by
// random frames, compared every cycle against a byte-level reference model.
module tb_speed_tracker;

  localparam int          ID_W  = 4;
  localparam int          SPW   = 8;
  localparam int          NS    = 2;
  localparam int          TMO   = 40;
  localparam logic [7:0]  SYNC  = 8'hA5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic [ID_W-1:0]    o_id;
  logic [SPW-1:0]     o_speed;
  logic               o_speed_valid;
  logic [NS*ID_W-1:0] o_slot_id;
  logic [NS*SPW-1:0]  o_slot_speed;
  logic [NS-1:0]      o_slot_valid;
  logic [7:0]         o_err_cnt;

  speed_tracker #(
    .DATA_W(8), .ID_W(ID_W), .SPEED_W(SPW), .NUM_SLOTS(NS),
    .SYNC_BYTE(SYNC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_id(o_id), .o_speed(o_speed), .o_speed_valid(o_speed_valid),
    .o_slot_id(o_slot_id), .o_slot_speed(o_slot_speed),
    .o_slot_valid(o_slot_valid), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; int id; int sp; } pulse_t;
  pulse_t pq[$];
  int  cyc = 0;
  int  m_phase, m_last_t, m_busy_end, m_err, m_id, m_x, m_oid, m_osp;
  bit  m_tv [16];
  int  m_tx [16];
  int  m_ty [16];
  int  sq_id[$];
  int  sq_sp[$];

  function automatic void model_reset();
    m_phase = 0; m_last_t = 0; m_busy_end = -100; m_err = 0;
    m_id = 0; m_x = 0; m_oid = 0; m_osp = 0;
    for (int i = 0; i < 16; i++) begin m_tv[i] = 1'b0; m_tx[i] = 0; m_ty[i] = 0; end
    sq_id.delete(); sq_sp.delete(); pq.delete();
  endfunction

  function automatic void err_bump();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void finish_frame(input int y, input int c);
    int dx, dy, sp;
    m_phase = 0;
    m_busy_end = c + 2;
    if (m_tv[m_id]) begin
      dx = (m_x > m_tx[m_id]) ? m_x - m_tx[m_id] : m_tx[m_id] - m_x;
      dy = (y > m_ty[m_id]) ? y - m_ty[m_id] : m_ty[m_id] - y;
      sp = (dx + dy > 255) ? 255 : dx + dy;
      pq.push_back('{c + 2, m_id, sp});
      for (int k = 0; k < sq_id.size(); k++) begin
        if (sq_id[k] == m_id) begin
          sq_id.delete(k); sq_sp.delete(k);
          break;
        end
      end
      if (sq_id.size() == NS) begin
        void'(sq_id.pop_back()); void'(sq_sp.pop_back());
      end
      sq_id.push_front(m_id); sq_sp.push_front(sp);
    end
    m_tv[m_id] = 1'b1; m_tx[m_id] = m_x; m_ty[m_id] = y;
  endfunction

  function automatic void model_byte(input logic [7:0] d, input int c);
    if (c <= m_busy_end) begin
      err_bump();
      return;
    end
    case (m_phase)
      0: if (d == SYNC) begin m_phase = 1; m_last_t = c; end
      1: begin
        if (d[7:4] != 4'd0) begin err_bump(); m_phase = 0; end
        else begin m_id = int'(d[3:0]); m_phase = 2; m_last_t = c; end
      end
      2: begin m_x = int'(d); m_phase = 3; m_last_t = c; end
      default: finish_frame(int'(d), c);
    endcase
  endfunction

  task automatic check_slots();
    logic [NS*ID_W-1:0] e_id;
    logic [NS*SPW-1:0]  e_sp;
    logic [NS-1:0]      e_v;
    e_id = '0; e_sp = '0; e_v = '0;
    for (int k = 0; k < NS; k++) begin
      if (k < sq_id.size()) begin
        e_id[k*ID_W +: ID_W] = ID_W'(sq_id[k]);
        e_sp[k*SPW +: SPW]   = SPW'(sq_sp[k]);
        e_v[k]               = 1'b1;
      end
    end
    check("slot_id", 32'(o_slot_id), 32'(e_id));
    check("slot_speed", 32'(o_slot_speed), 32'(e_sp));
    check("slot_valid", 32'(o_slot_valid), 32'(e_v));
  endtask

  // One clock: check outputs at the falling edge, then drive the next input.
  task automatic step(input bit v, input logic [7:0] d);
    bit exp_p;
    @(negedge clk);
    cyc++;
    if (m_phase != 0 && cyc >= m_last_t + TMO + 1) begin
      err_bump();
      m_phase = 0;
    end
    exp_p = (pq.size() > 0) && (pq[0].cyc == cyc);
    check("speed_valid", 32'(o_speed_valid), 32'(exp_p));
    if (exp_p) begin
      m_oid = pq[0].id; m_osp = pq[0].sp;
      void'(pq.pop_front());
    end
    check("o_id", 32'(o_id), 32'(m_oid));
    check("o_speed", 32'(o_speed), 32'(m_osp));
    check("err_cnt", 32'(o_err_cnt), 32'(m_err));
    if (cyc > m_busy_end) check_slots();
    rx_valid = v;
    rx_data  = v ? d : 8'h00;
    if (v) model_byte(d, cyc);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step(1'b0, 8'h00);
    step(1'b1, b);
  endtask

  task automatic frame(input logic [7:0] id, input logic [7:0] x, input logic [7:0] y);
    send(SYNC, 3); send(id, 0); send(x, 0); send(y, 0);
  endtask

  task automatic settle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    #1;
    check("rst_speed_valid", 32'(o_speed_valid), 32'd0);
    check("rst_id", 32'(o_id), 32'd0);
    check("rst_speed", 32'(o_speed), 32'd0);
    check("rst_slot_id", 32'(o_slot_id), 32'd0);
    check("rst_slot_speed", 32'(o_slot_speed), 32'd0);
    check("rst_slot_valid", 32'(o_slot_valid), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    int kind, pre, g1, g2, g3;
    logic [7:0] idb;
    model_reset();
    do_reset();

    // First sighting then a move of (3,-4): speed 7.
    frame(8'h03, 8'h10, 8'h20);
    frame(8'h03, 8'h13, 8'h1C);
    settle(4);
    check("tp1_id", 32'(o_id), 32'd3);
    check("tp1_speed", 32'(o_speed), 32'd7);
    check("tp1_slots", 32'(o_slot_valid), 32'd1);
    check("tp1_slot0", 32'(o_slot_id), 32'h03);

    // Saturation: 510 clips to 255.
    frame(8'h01, 8'h00, 8'h00);
    frame(8'h01, 8'hFF, 8'hFF);
    settle(4);
    check("tp2_speed", 32'(o_speed), 32'd255);

    // Eviction and re-promotion without duplicates.
    frame(8'h02, 8'h05, 8'h05); frame(8'h02, 8'h06, 8'h05);
    frame(8'h03, 8'h00, 8'h00); frame(8'h03, 8'h01, 8'h00);
    settle(4);
    check("tp3_evict", 32'(o_slot_id), 32'h23);
    frame(8'h02, 8'h08, 8'h05);
    settle(4);
    check("tp3_promote", 32'(o_slot_id), 32'h32);
    check("tp3_valid", 32'(o_slot_valid), 32'd3);

    // Reset between X and Y clears the table.
    frame(8'h04, 8'h01, 8'h01);
    send(SYNC, 3); send(8'h04, 0); send(8'h09, 0);
    do_reset();
    frame(8'h04, 8'h02, 8'h02);
    settle(4);

    // Bad ID byte.
    send(SYNC, 2); send(8'h25, 0);
    settle(2);
    check("tp4_err", 32'(o_err_cnt), 32'd1);
    frame(8'h04, 8'h03, 8'h03);
    settle(4);
    check("tp4_parse", 32'(o_speed), 32'd2);

    // Timeout mid-frame; the following frame is a first sighting.
    send(SYNC, 2); send(8'h05, 0); send(8'h10, 0);
    settle(TMO + 2);
    check("tp5_err", 32'(o_err_cnt), 32'd2);
    frame(8'h05, 8'h10, 8'h10);
    settle(4);
    // Gap one short of the timeout keeps the frame alive; exactly TMO aborts.
    send(SYNC, 3); send(8'h05, TMO - 1); send(8'h12, TMO - 1); send(8'h10, TMO - 1);
    send(SYNC, 3); send(8'h05, 0); send(8'h20, TMO); send(8'h20, 0);
    settle(4);

    // Random frames, gaps, junk and bytes inside the busy window.
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      idb  = (kind == 0) ? 8'(($urandom_range(1, 15) << 4) | $urandom_range(0, 15))
                         : 8'($urandom_range(0, 6));
      pre = int'($urandom_range(0, 4));
      g1 = int'($urandom_range(0, 2)); g2 = int'($urandom_range(0, 2)); g3 = int'($urandom_range(0, 2));
      if (kind == 1) g2 = TMO - 1 + int'($urandom_range(0, 2));
      if (kind == 2) send(8'($urandom_range(0, 255)), pre);
      send(SYNC, pre); send(idb, g1);
      send(8'($urandom_range(0, 255)), g2);
      send(8'($urandom_range(0, 255)), g3);
    end
    settle(TMO + 4);

    // Error counter saturation.
    for (int i = 0; i < 270; i++) begin
      send(SYNC, 0); send(8'hF0, 0);
    end
    settle(3);
    check("err_sat", 32'(o_err_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
